// File: rtl/commit_overlay.sv
// commit_overlay: 8-digit hex commit-ID text overlay (5x7 font, SCALE-scaled) plus a free-running blink flag.
// Define COMMIT_OVERLAY_BLINK_EN to gate the overlay with blink so the text flashes.
`default_nettype none

module commit_overlay #(
  parameter int          BLINK_BITS = 26,
  parameter logic [31:0] COMMIT     = 32'h0,
  parameter int          X0         = 0,
  parameter int          Y0         = 0,
  parameter int          SCALE      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       hsync,
  input  logic       active,
  input  logic [2:0] phase,
  output logic [3:0] ovl,
  output logic       blink
);

  localparam logic [10:0] X0_GRP  = 11'(X0 / 4);
  localparam logic [9:0]  Y0_LINE = 10'(Y0);
  localparam logic [2:0]  SUB_MAX = 3'(SCALE - 1);

  logic [BLINK_BITS-1:0] cnt;
  logic [10:0] x_grp;
  logic [9:0]  y_line;
  logic        active_d;
  logic        x_started, y_started;
  logic [7:0]  dot_x;
  logic [2:0]  sub_x;
  logic [3:0]  dot_y;
  logic [2:0]  sub_y;

  logic        x_ok, y_ok, line_end;
  logic [10:0] lane_ds [5];
  logic [7:0]  lane_dot;
  logic [4:0]  row_bits, row_shift;
  logic [3:0]  raw;
  logic        unused_phase;

  assign unused_phase = ^phase;

  function automatic logic [34:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      4'h1: glyph = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      4'h2: glyph = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      4'h3: glyph = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      4'h4: glyph = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      4'h5: glyph = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      4'h6: glyph = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      4'h7: glyph = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      4'h8: glyph = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      4'h9: glyph = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      4'hA: glyph = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11};
      4'hB: glyph = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      4'hC: glyph = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      4'hD: glyph = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      4'hE: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      default: glyph = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
    endcase
  endfunction

  function automatic logic [4:0] glyph_row(input logic [34:0] g, input logic [2:0] r);
    case (r)
      3'd0: glyph_row = g[34:30];
      3'd1: glyph_row = g[29:25];
      3'd2: glyph_row = g[24:20];
      3'd3: glyph_row = g[19:15];
      3'd4: glyph_row = g[14:10];
      3'd5: glyph_row = g[9:5];
      3'd6: glyph_row = g[4:0];
      default: glyph_row = 5'h00;
    endcase
  endfunction

  // Advance a {dot, sub-dot} pair by one pixel; sub-dot wraps at SCALE, replacing a divider.
  function automatic logic [10:0] step_x(input logic [10:0] ds);
    if (ds[2:0] == SUB_MAX) step_x = {ds[10:3] + 8'd1, 3'd0};
    else                    step_x = {ds[10:3], ds[2:0] + 3'd1};
  endfunction

  function automatic logic [6:0] step_y(input logic [6:0] ds);
    if (ds[2:0] == SUB_MAX) step_y = {ds[6:3] + 4'd1, 3'd0};
    else                    step_y = {ds[6:3], ds[2:0] + 3'd1};
  endfunction

  assign x_ok     = x_started || (x_grp == X0_GRP);
  assign y_ok     = y_started || (y_line == Y0_LINE);
  assign line_end = active_d && !active;
  assign blink    = cnt[BLINK_BITS-1];

  always_comb begin
    lane_ds[0] = {dot_x, sub_x};
    for (int i = 0; i < 4; i++) lane_ds[i+1] = step_x(lane_ds[i]);
    raw       = '0;
    lane_dot  = '0;
    row_bits  = '0;
    row_shift = '0;
    for (int i = 0; i < 4; i++) begin
      lane_dot  = lane_ds[i][10:3];
      row_bits  = glyph_row(glyph(COMMIT[{~lane_dot[5:3], 2'b00} +: 4]), dot_y[2:0]);
      // Column 0 maps to the row MSB; columns 5..7 shift out to zero.
      row_shift = row_bits << lane_dot[2:0];
      raw[i]    = active && x_ok && y_ok && (lane_dot < 8'd64) && (dot_y < 4'd7) && row_shift[4];
    end
  end

`ifdef COMMIT_OVERLAY_BLINK_EN
  assign ovl = raw & {4{blink}};
`else
  assign ovl = raw;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      x_grp     <= '0;
      y_line    <= '0;
      active_d  <= 1'b0;
      x_started <= 1'b0;
      y_started <= 1'b0;
      dot_x     <= '0;
      sub_x     <= '0;
      dot_y     <= '0;
      sub_y     <= '0;
    end else begin
      cnt      <= cnt + BLINK_BITS'(1);
      active_d <= active;

      if (hsync || !active) begin
        x_grp     <= '0;
        x_started <= 1'b0;
        dot_x     <= '0;
        sub_x     <= '0;
      end else begin
        x_grp <= x_grp + 11'd1;
        if (x_ok) begin
          x_started <= 1'b1;
          if (dot_x < 8'd64) {dot_x, sub_x} <= lane_ds[4];
        end
      end

      if (vsync) begin
        y_line    <= '0;
        y_started <= 1'b0;
        dot_y     <= '0;
        sub_y     <= '0;
      end else if (line_end && (y_line != 10'd1023)) begin
        y_line <= y_line + 10'd1;
        if (y_ok) begin
          y_started <= 1'b1;
          if (dot_y < 4'd8) {dot_y, sub_y} <= step_y({dot_y, sub_y});
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_commit_overlay.sv
// Testbench for commit_overlay: directed vector table, multi-line sequences and a random
// stream compared against a pixel-coordinate reference model across four parameter sets.
`default_nettype none

module tb_commit_overlay;

  localparam int          NI        = 4;
  localparam int          P_BB [NI] = '{4, 4, 26, 5};
  localparam logic [31:0] P_C  [NI] = '{32'h0, 32'hF0000000, 32'h1A2B3C4D, 32'h9E7D5B60};
  localparam int          P_X0 [NI] = '{0, 0, 8, 4};
  localparam int          P_Y0 [NI] = '{0, 0, 3, 1};
  localparam int          P_S  [NI] = '{1, 1, 3, 2};

  localparam bit [4:0] FONT [112] = '{
    5'h0E,5'h11,5'h13,5'h15,5'h19,5'h11,5'h0E,  5'h04,5'h0C,5'h04,5'h04,5'h04,5'h04,5'h0E,
    5'h0E,5'h11,5'h01,5'h02,5'h04,5'h08,5'h1F,  5'h1F,5'h02,5'h04,5'h02,5'h01,5'h11,5'h0E,
    5'h02,5'h06,5'h0A,5'h12,5'h1F,5'h02,5'h02,  5'h1F,5'h10,5'h1E,5'h01,5'h01,5'h11,5'h0E,
    5'h06,5'h08,5'h10,5'h1E,5'h11,5'h11,5'h0E,  5'h1F,5'h01,5'h02,5'h04,5'h08,5'h08,5'h08,
    5'h0E,5'h11,5'h11,5'h0E,5'h11,5'h11,5'h0E,  5'h0E,5'h11,5'h11,5'h0F,5'h01,5'h02,5'h0C,
    5'h0E,5'h11,5'h11,5'h11,5'h1F,5'h11,5'h11,  5'h1E,5'h11,5'h11,5'h1E,5'h11,5'h11,5'h1E,
    5'h0E,5'h11,5'h10,5'h10,5'h10,5'h11,5'h0E,  5'h1C,5'h12,5'h11,5'h11,5'h11,5'h12,5'h1C,
    5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h1F,  5'h1F,5'h10,5'h10,5'h1E,5'h10,5'h10,5'h10
  };

  logic       clk = 1'b0;
  logic       reset, vsync, hsync, active;
  logic [2:0] phase;
  logic [3:0] ovl_w [NI];
  logic       blink_w [NI];

  always #5 clk = ~clk;

  commit_overlay #(.BLINK_BITS(4), .COMMIT(32'h0), .X0(0), .Y0(0), .SCALE(1)) u_a (
    .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync), .active(active), .phase(phase),
    .ovl(ovl_w[0]), .blink(blink_w[0]));
  commit_overlay #(.BLINK_BITS(4), .COMMIT(32'hF0000000), .X0(0), .Y0(0), .SCALE(1)) u_b (
    .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync), .active(active), .phase(phase),
    .ovl(ovl_w[1]), .blink(blink_w[1]));
  commit_overlay #(.BLINK_BITS(26), .COMMIT(32'h1A2B3C4D), .X0(8), .Y0(3), .SCALE(3)) u_c (
    .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync), .active(active), .phase(phase),
    .ovl(ovl_w[2]), .blink(blink_w[2]));
  commit_overlay #(.BLINK_BITS(5), .COMMIT(32'h9E7D5B60), .X0(4), .Y0(1), .SCALE(2)) u_d (
    .clk(clk), .reset(reset), .vsync(vsync), .hsync(hsync), .active(active), .phase(phase),
    .ovl(ovl_w[3]), .blink(blink_w[3]));

  int     n_tests = 0;
  int     n_fail  = 0;
  int     mx = 0, my = 0;
  bit     pa = 1'b0;
  longint cyc = 0;

  typedef struct {
    bit         v, h, a;
    logic [3:0] ea, eb;
  } vec_t;

  function automatic bit model_blink(int k);
    longint m;
    m = cyc % (longint'(1) << P_BB[k]);
    return ((m >> (P_BB[k] - 1)) & 1) != 0;
  endfunction

  function automatic logic [3:0] model_ovl(int k, bit a);
    logic [3:0] r;
    logic [4:0] fr;
    int x, y, s, dx, dy, digit, col, row, nib;
    r = '0;
    s = P_S[k];
    if (a) begin
      for (int i = 0; i < 4; i++) begin
        x = 4 * mx + i;
        y = my;
        if (x >= P_X0[k] && x < P_X0[k] + 64 * s && y >= P_Y0[k] && y < P_Y0[k] + 8 * s) begin
          dx = x - P_X0[k];
          dy = y - P_Y0[k];
          digit = dx / (8 * s);
          col = (dx / s) % 8;
          row = dy / s;
          if (col < 5 && row < 7) begin
            nib = int'((P_C[k] >> (28 - 4 * digit)) & 32'hF);
            fr = FONT[nib * 7 + row];
            r[i] = fr[4 - col];
          end
        end
      end
    end
`ifdef COMMIT_OVERLAY_BLINK_EN
    if (!model_blink(k)) r = '0;
`endif
    return r;
  endfunction

  function automatic logic [3:0] blink_mask(int k, logic [3:0] e);
`ifdef COMMIT_OVERLAY_BLINK_EN
    return model_blink(k) ? e : 4'b0000;
`else
    return e;
`endif
  endfunction

  task automatic cmp4(string name, logic [3:0] act, logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d, x_grp %0d, line %0d)", name, act, exp, cyc, mx, my);
    end
  endtask

  task automatic cmp1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NI; k++) begin
      cmp4($sformatf("model_ovl[%0d]", k), ovl_w[k], model_ovl(k, active));
      cmp1($sformatf("model_blink[%0d]", k), blink_w[k], model_blink(k));
    end
  endtask

  task automatic apply(bit v, bit h, bit a);
    vsync = v; hsync = h; active = a; phase = 3'($urandom);
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (hsync || !active) mx = 0; else mx = (mx + 1) % 2048;
    if (vsync) my = 0;
    else if (pa && !active && my < 1023) my++;
    pa = active;
    cyc++;
    #1;
  endtask

  task automatic tick(bit v, bit h, bit a);
    apply(v, h, a);
    check_model();
    finish_cycle();
  endtask

  vec_t tbl [12];
  bit   ra;

  initial begin
    tbl[0]  = '{1, 1, 0, 4'b0000, 4'b0000};  // vsync and hsync together
    tbl[1]  = '{0, 0, 0, 4'b0000, 4'b0000};
    tbl[2]  = '{0, 0, 1, 4'b1110, 4'b1111};  // line 0, group 0
    tbl[3]  = '{0, 0, 1, 4'b0000, 4'b0001};  // line 0, group 1
    tbl[4]  = '{0, 0, 0, 4'b0000, 4'b0000};
    tbl[5]  = '{0, 0, 1, 4'b0001, 4'b0001};  // line 1, group 0
    tbl[6]  = '{0, 0, 1, 4'b0001, 4'b0000};  // line 1, group 1
    tbl[7]  = '{0, 1, 1, 4'b0001, 4'b0001};  // group 2 shown while hsync clears x
    tbl[8]  = '{0, 0, 1, 4'b0001, 4'b0001};  // back at group 0
    tbl[9]  = '{0, 0, 0, 4'b0000, 4'b0000};
    tbl[10] = '{1, 0, 0, 4'b0000, 4'b0000};
    tbl[11] = '{0, 0, 0, 4'b0000, 4'b0000};

    reset = 1'b0; vsync = 1'b0; hsync = 1'b0; active = 1'b0; phase = 3'd0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      cmp4($sformatf("reset_ovl[%0d]", k), ovl_w[k], 4'b0000);
      cmp1($sformatf("reset_blink[%0d]", k), blink_w[k], 1'b0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    for (int n = 0; n <= 16; n++) begin
      apply(0, 0, 0);
      cmp1($sformatf("blink_at_%0d", n), blink_w[0], (n >= 8 && n <= 15));
      check_model();
      finish_cycle();
    end

    for (int t = 0; t < 12; t++) begin
      apply(tbl[t].v, tbl[t].h, tbl[t].a);
      cmp4($sformatf("vec%0d_a", t), ovl_w[0], blink_mask(0, tbl[t].ea));
      cmp4($sformatf("vec%0d_b", t), ovl_w[1], blink_mask(1, tbl[t].eb));
      check_model();
      finish_cycle();
    end

    // Lines 0..7 in full, then line 8 sits below the SCALE=1 text box.
    for (int ln = 0; ln < 9; ln++) begin
      for (int g = 0; g < 20; g++) begin
        apply(0, 0, 1);
        if (ln == 8) cmp4($sformatf("below_box_g%0d", g), ovl_w[0], 4'b0000);
        check_model();
        finish_cycle();
      end
      tick(0, 0, 0);
    end

    ra = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      if (ra) ra = ($urandom_range(99) < 95);
      else    ra = ($urandom_range(99) < 25);
      tick($urandom_range(399) == 0, $urandom_range(59) == 0, ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
